// File: rtl/wide_lzc_sequencer_if.sv
// Operand/result handshake bundle for the wide leading-zero-count sequencer.
// Master is the producer/consumer side; slave is the sequencer itself.
interface wide_lzc_sequencer_if #(
  parameter int TOTAL_WIDTH = 256,
  parameter int TAG_WIDTH   = 5
);
  localparam int COUNT_WIDTH = $clog2(TOTAL_WIDTH) + 1;

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [TOTAL_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_zero;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic                   busy;

  modport master (
    output flush, in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_tag, busy
  );
endinterface

// File: rtl/wide_lzc_sequencer.sv
// Multi-cycle leading-zero counter: walks a wide operand MSB-first through one
// CHUNK_WIDTH LZC slice per cycle and stops at the first slice holding a one.
module wide_lzc_sequencer #(
  parameter int TOTAL_WIDTH = 256,
  parameter int CHUNK_WIDTH = 64,
  parameter int TAG_WIDTH   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  wide_lzc_sequencer_if.slave lzc
);
  localparam int NUM_CHUNKS      = TOTAL_WIDTH / CHUNK_WIDTH;
  localparam int IDX_WIDTH       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int COUNT_WIDTH     = $clog2(TOTAL_WIDTH) + 1;
  localparam int SLICE_CNT_WIDTH = $clog2(CHUNK_WIDTH) + 1;

  localparam logic [IDX_WIDTH-1:0]   LAST_IDX   = IDX_WIDTH'(NUM_CHUNKS - 1);
  localparam logic [COUNT_WIDTH-1:0] CHUNK_STEP = COUNT_WIDTH'(CHUNK_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(TOTAL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Leading zeros of one slice; the highest set bit wins because it is visited last.
  function automatic logic [SLICE_CNT_WIDTH-1:0] slice_lzc(input logic [CHUNK_WIDTH-1:0] slice);
    logic [SLICE_CNT_WIDTH-1:0] cnt;
    cnt = SLICE_CNT_WIDTH'(CHUNK_WIDTH);
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (slice[i]) begin
        cnt = SLICE_CNT_WIDTH'(CHUNK_WIDTH - 1 - i);
      end
    end
    return cnt;
  endfunction

  state_t                     state_r,     state_s;
  logic [TOTAL_WIDTH-1:0]     operand_r,   operand_s;
  logic [IDX_WIDTH-1:0]       idx_r,       idx_s;
  logic [COUNT_WIDTH-1:0]     acc_r,       acc_s;
  logic [TAG_WIDTH-1:0]       tag_r,       tag_s;
  logic [COUNT_WIDTH-1:0]     out_count_r, out_count_s;
  logic                       out_zero_r,  out_zero_s;
  logic [TAG_WIDTH-1:0]       out_tag_r,   out_tag_s;
  logic                       out_valid_r;
  logic                       in_ready_r;
  logic                       busy_r;

  logic [CHUNK_WIDTH-1:0]     top_slice_s;
  logic [SLICE_CNT_WIDTH-1:0] slice_count_s;
  logic                       slice_found_s;

  // Slice datapath: only the operand register feeds it, never in_data.
  always_comb begin
    top_slice_s   = operand_r[TOTAL_WIDTH-1 -: CHUNK_WIDTH];
    slice_count_s = slice_lzc(top_slice_s);
    slice_found_s = |top_slice_s;
  end

  // Next-state and next-register-value logic; flush overrides everything.
  always_comb begin
    state_s     = state_r;
    operand_s   = operand_r;
    idx_s       = idx_r;
    acc_s       = acc_r;
    tag_s       = tag_r;
    out_count_s = out_count_r;
    out_zero_s  = out_zero_r;
    out_tag_s   = out_tag_r;
    if (lzc.flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (lzc.in_valid && in_ready_r) begin
            operand_s = lzc.in_data;
            tag_s     = lzc.in_tag;
            acc_s     = {COUNT_WIDTH{1'b0}};
            idx_s     = {IDX_WIDTH{1'b0}};
            state_s   = SCAN;
          end else begin
            state_s = IDLE;
          end
        end
        SCAN: begin
          if (slice_found_s) begin
            out_count_s = acc_r + COUNT_WIDTH'(slice_count_s);
            out_zero_s  = 1'b0;
            out_tag_s   = tag_r;
            state_s     = DONE;
          end else if (idx_r == LAST_IDX) begin
            out_count_s = FULL_COUNT;
            out_zero_s  = 1'b1;
            out_tag_s   = tag_r;
            state_s     = DONE;
          end else begin
            acc_s     = acc_r + CHUNK_STEP;
            operand_s = operand_r << CHUNK_WIDTH;
            idx_s     = idx_r + IDX_WIDTH'(1);
            state_s   = SCAN;
          end
        end
        DONE: begin
          if (out_valid_r && lzc.out_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      operand_r   <= {TOTAL_WIDTH{1'b0}};
      idx_r       <= {IDX_WIDTH{1'b0}};
      acc_r       <= {COUNT_WIDTH{1'b0}};
      tag_r       <= {TAG_WIDTH{1'b0}};
      out_count_r <= {COUNT_WIDTH{1'b0}};
      out_zero_r  <= 1'b0;
      out_tag_r   <= {TAG_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      operand_r   <= operand_s;
      idx_r       <= idx_s;
      acc_r       <= acc_s;
      tag_r       <= tag_s;
      out_count_r <= out_count_s;
      out_zero_r  <= out_zero_s;
      out_tag_r   <= out_tag_s;
      out_valid_r <= (state_s == DONE);
      in_ready_r  <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign lzc.out_valid = out_valid_r;
  assign lzc.in_ready  = in_ready_r;
  assign lzc.busy      = busy_r;
  assign lzc.out_count = out_count_r;
  assign lzc.out_zero  = out_zero_r;
  assign lzc.out_tag   = out_tag_r;
endmodule

// File: tb/tb_wide_lzc_sequencer.sv
// Directed bench for wide_lzc_sequencer with a cycle-level behavioural model
// (count from a bit scan, latency from which 64-bit slice holds the first one).
module tb_wide_lzc_sequencer;
  localparam int TW   = 256;
  localparam int CW   = 64;
  localparam int TGW  = 5;
  localparam int NCH  = TW / CW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  wide_lzc_sequencer_if #(.TOTAL_WIDTH(TW), .TAG_WIDTH(TGW)) bus();

  wide_lzc_sequencer #(.TOTAL_WIDTH(TW), .CHUNK_WIDTH(CW), .TAG_WIDTH(TGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lzc   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lzc(input logic [TW-1:0] v);
    for (int i = TW - 1; i >= 0; i--) begin
      if (v[i]) return TW - 1 - i;
    end
    return TW;
  endfunction

  function automatic int ref_latency(input int cnt);
    return (cnt >= TW) ? NCH : (cnt / CW) + 1;
  endfunction

  function automatic logic [TW-1:0] onehot(input int pos);
    logic [TW-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  // Behavioural model: idle / waiting-for-latency / holding a result.
  logic            m_idle, m_valid, m_zero;
  int              m_remain, m_count, p_count;
  logic [TGW-1:0]  m_tag, p_tag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_remain <= 0;
      m_count <= 0; m_zero <= 1'b0; m_tag <= '0;
    end else if (bus.flush) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_remain <= 0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        p_count  <= ref_lzc(bus.in_data);
        p_tag    <= bus.in_tag;
        m_remain <= ref_latency(ref_lzc(bus.in_data));
        m_idle   <= 1'b0;
      end
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0; m_idle <= 1'b1;
      end
    end else begin
      m_remain <= m_remain - 1;
      if (m_remain == 1) begin
        m_valid <= 1'b1;
        m_count <= p_count;
        m_zero  <= (p_count == TW);
        m_tag   <= p_tag;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_out_valid", bus.out_valid, m_valid);
      check("cyc_in_ready", bus.in_ready, m_idle);
      check("cyc_busy", bus.busy, !m_idle);
      if (m_valid) begin
        check("cyc_out_count", bus.out_count, m_count);
        check("cyc_out_zero", bus.out_zero, m_zero);
        check("cyc_out_tag", bus.out_tag, m_tag);
      end
    end
  end

  task automatic check_reset(input string name);
    check({name, "_out_valid"}, bus.out_valid, 1'b0);
    check({name, "_out_count"}, bus.out_count, 9'd0);
    check({name, "_out_zero"}, bus.out_zero, 1'b0);
    check({name, "_out_tag"}, bus.out_tag, 5'd0);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  // Offer one operand while idle, then wait (bounded) for out_valid.
  task automatic run_op(input string name, input logic [TW-1:0] data, input logic [TGW-1:0] tag,
                        input int exp_count, input int exp_lat);
    int cyc;
    bus.in_data  = data;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    bus.in_tag   = ~tag;
    cyc = 0;
    while (!bus.out_valid && cyc < 12) begin
      check({name, "_in_ready_scan"}, bus.in_ready, 1'b0);
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_count"}, bus.out_count, exp_count);
    check({name, "_zero"}, bus.out_zero, (exp_count == TW));
    check({name, "_tag"}, bus.out_tag, tag);
    check({name, "_in_ready_done"}, bus.in_ready, 1'b0);
  endtask

  task automatic consume(input string name);
    @(posedge clk); #1;
    check({name, "_idle_in_ready"}, bus.in_ready, 1'b1);
    check({name, "_idle_out_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Pin the model with hand-computed values.
    check("pin_lzc_msb", ref_lzc(onehot(255)), 0);
    check("pin_lzc_b100", ref_lzc(onehot(100)), 155);
    check("pin_lzc_b0", ref_lzc(onehot(0)), 255);
    check("pin_lzc_zero", ref_lzc('0), 256);
    check("pin_lzc_b16", ref_lzc(onehot(16)), 239);
    check("pin_lat_b100", ref_latency(155), 3);
    check("pin_lat_zero", ref_latency(256), 4);

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    run_op("t1_msb", onehot(255), 5'd3, 0, 1);
    consume("t1");

    run_op("t2_b100", onehot(100), 5'd7, 155, 3);
    consume("t2a");
    run_op("t2_b0", onehot(0), 5'd9, 255, 4);
    consume("t2b");

    run_op("t3_zero", '0, 5'd21, 256, 4);
    consume("t3");

    // Backpressure: result held, extra operand not taken.
    bus.out_ready = 1'b0;
    run_op("t4_b200", onehot(200), 5'd12, 55, 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = onehot(3);
      bus.in_tag   = 5'd30;
      @(posedge clk); #1;
      check("t4_hold_valid", bus.out_valid, 1'b1);
      check("t4_hold_count", bus.out_count, 9'd55);
      check("t4_hold_tag", bus.out_tag, 5'd12);
      check("t4_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    consume("t4");

    // Flush in the second SCAN cycle of an all-zero operand.
    bus.in_data  = '0;
    bus.in_tag   = 5'd4;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_scan_busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("t5_flush_busy", bus.busy, 1'b0);
    check("t5_flush_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("t5_no_valid", bus.out_valid, 1'b0);
      @(posedge clk); #1;
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = onehot(255);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_idle_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("t5_flush_idle_valid", bus.out_valid, 1'b0);

    // Asynchronous reset mid-SCAN.
    bus.in_data  = '0;
    bus.in_tag   = 5'd5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_scan_busy", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset("t6_rst_scan");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-DONE.
    bus.out_ready = 1'b0;
    run_op("t6_done", onehot(100), 5'd17, 155, 3);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1 check_reset("t6_rst_done");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    run_op("t6_b16", onehot(16), 5'd2, 239, 4);
    consume("t6");

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wide_lzc_sequencer.md
Name: wide_lzc_sequencer

Overview:
Multi-cycle leading-zero counter for operands wider than one LZC slice. It holds a wide operand and feeds CHUNK_WIDTH slices, MSB-first, into a single internal CHUNK_WIDTH LZC datapath, one slice per cycle. It stops early at the first slice containing a one and returns the total count with a valid/ready handshake. It serves the normalize stage of wide-accumulator and FP paths in the shader core, where one 64-bit LZC is reused instead of building a 256-bit one.

Parameters:
TOTAL_WIDTH, 256, operand width in bits; must be an integer multiple of CHUNK_WIDTH.
CHUNK_WIDTH, 64, width of the internal LZC slice.
TAG_WIDTH, 5, sideband tag width (lane/thread id), carried unmodified.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort; drops any in-flight or pending result.
in_valid  input  1  operand offered.
in_ready  output  1  block can accept an operand (high only in IDLE).
in_data  input  TOTAL_WIDTH  operand.
in_tag  input  TAG_WIDTH  sideband tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_count  output  $clog2(TOTAL_WIDTH)+1  leading-zero count, 0..TOTAL_WIDTH.
out_zero  output  1  operand was all zeros (out_count == TOTAL_WIDTH).
out_tag  output  TAG_WIDTH  tag of the operand that produced this result.
busy  output  1  state != IDLE.

Behaviour:
- One clock; reset is asynchronous, active-low (rst_n). All state is reset asynchronously.
- Reset values: state IDLE; out_valid 0, out_count 0, out_zero 0, out_tag 0, busy 0; in_ready 1 once IDLE. The operand register, chunk index and accumulator are cleared to 0.
- NUM_CHUNKS = TOTAL_WIDTH/CHUNK_WIDTH. The chunk index is $clog2(NUM_CHUNKS) bits wide, minimum 1. The accumulator has the same width as out_count.
- Internal LZC slice: combinational. On the top CHUNK_WIDTH bits of the operand register it gives slice_count, which is the number of leading zeros (CHUNK_WIDTH if the slice is zero), and slice_found.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready & !flush: latch in_data and in_tag, set accumulator = 0 and chunk index = 0, go to SCAN.
  - SCAN: each cycle, evaluate the top slice.
    - If slice_found: out_count <= accumulator + slice_count, out_zero <= 0, go to DONE.
    - Else if chunk index == NUM_CHUNKS-1: out_count <= TOTAL_WIDTH, out_zero <= 1, go to DONE.
    - Else: accumulator += CHUNK_WIDTH, operand register shifts left by CHUNK_WIDTH with zero fill, chunk index += 1.
  - DONE: out_valid = 1. out_count, out_zero and out_tag are held stable until out_valid & out_ready. On that handshake, return to IDLE. There is no same-cycle re-accept; in_ready stays 0 in DONE.
- Latency: if the first one lies in slice k (k = 0 is the MSB slice), out_valid rises k+1 cycles after the accept edge. An all-zero operand takes NUM_CHUNKS cycles.
- Throughput: one operand per (latency + 1 + consumer stall) cycles.
- flush:
  - From any state, the next state is IDLE and out_valid drops the next cycle.
  - out_count, out_zero and out_tag keep their last values; they are don't-care without out_valid.
  - flush in IDLE with in_valid: no accept.
  - flush in DONE with out_ready: the result is treated as dropped; the consumer must ignore it.
- Reset mid-SCAN or mid-DONE: immediate return to reset values; the in-flight operand is lost.
- in_data and in_tag are sampled only on the accept edge; later changes are ignored.
- The operand register is the only source feeding the LZC slice; in_data never feeds it directly.
- out_count is never greater than TOTAL_WIDTH. The accumulator never overflows, since its maximum value is TOTAL_WIDTH-CHUNK_WIDTH before the final add.

Test Plan:
1. Defaults (256/64), out_ready=1. Accept in_data = 1<<255, tag 3. Required: out_valid 1 cycle after accept; out_count=0, out_zero=0, out_tag=3.
2. in_data = 1<<100 (slice 2, position 27 within slice). Required: out_valid 3 cycles after accept, out_count=155. Then in_data = 1 (slice 3). Required: 4 cycles, out_count=255.
3. in_data = 0. Required: out_valid after 4 cycles, out_count=256, out_zero=1. in_ready=0 throughout SCAN and DONE.
4. Backpressure: out_ready=0 for 5 cycles after out_valid. Required: out_count and out_tag stable and out_valid held. in_valid offered meanwhile is not accepted. After out_ready=1: IDLE next cycle, in_ready=1.
5. flush asserted in the 2nd SCAN cycle of an all-zero operand. Required: IDLE next cycle, out_valid never asserted, busy=0. flush together with in_valid in IDLE: no accept.
6. rst_n pulsed low asynchronously mid-SCAN and mid-DONE. Required: outputs go to their reset values immediately without a clock. After release, a new operand 0x0…01_0000 (bit 16) gives out_count=239.
